// File: rtl/mp1000_pkg.sv
// Shared types and default memory-map constants for the MP1000 ROM loader.
package mp1000_pkg;

    // Arbiter states; CPU reads take two cycles because memory read data lags one cycle.
    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CPU_RD,
        ARB_CPU_DONE,
        ARB_CPU_WR,
        ARB_DL_WR
    } arb_state_e;

    // Owner of the most recent memory grant, used to alternate priority.
    typedef enum logic {
        GRANT_CPU,
        GRANT_DL
    } grant_e;

    localparam logic [7:0]  MP_BIOS_INDEX = 8'd0;
    localparam logic [7:0]  MP_CART_INDEX = 8'd1;
    localparam int unsigned MP_BIOS_BASE  = 'h0000;
    localparam int unsigned MP_BIOS_SIZE  = 2048;
    localparam int unsigned MP_CART_BASE  = 'h0800;
    localparam int unsigned MP_CART_SIZE  = 8192;
    localparam int unsigned MP_RESET_HOLD = 16;

    // Larger of two 16-bit values.
    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mp1000_dl_fifo.sv
// Small synchronous FIFO buffering {address, byte} download entries.
module mp1000_dl_fifo #(
    parameter int unsigned DW    = 23,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // Pointer and count registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mp1000_load_arbiter.sv
// Routes ioctl ROM downloads into system memory, shares the memory port with the CPU,
// and holds the core in reset while an image is loading.
module mp1000_load_arbiter
    import mp1000_pkg::*;
#(
    parameter int unsigned AW         = 15,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  BIOS_INDEX = MP_BIOS_INDEX,
    parameter logic [7:0]  CART_INDEX = MP_CART_INDEX,
    parameter int unsigned BIOS_BASE  = MP_BIOS_BASE,
    parameter int unsigned BIOS_SIZE  = MP_BIOS_SIZE,
    parameter int unsigned CART_BASE  = MP_CART_BASE,
    parameter int unsigned CART_SIZE  = MP_CART_SIZE,
    parameter int unsigned RESET_HOLD = MP_RESET_HOLD
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          core_reset,
    output logic          bios_loaded,
    output logic          cart_loaded,
    output logic [15:0]   cart_size,
    output logic          overflow
);

    localparam int unsigned DW = AW + 8;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_wdata, fifo_rdata;
    logic [CW-1:0] fifo_count, fifo_count_next;

    // Download edge detect and push filter
    logic          dl_q, dl_rise, dl_fall;
    logic          bios_hit, cart_hit, push_req;
    logic [AW-1:0] push_addr;
    logic [15:0]   cart_off1;

    // Arbiter FSM state and registered memory/CPU outputs
    arb_state_e    state_q, state_d;
    grant_e        last_grant_q, last_grant_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;

    // Status, hold counter and loader throttle
    logic          ioctl_wait_q, ioctl_wait_d;
    logic          core_reset_q, core_reset_d;
    logic [15:0]   hold_q, hold_d;
    logic          bios_loaded_q, bios_loaded_d;
    logic          cart_loaded_q, cart_loaded_d;
    logic [15:0]   cart_size_q, cart_size_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    idx_q, idx_d;
    logic          end_pend_q, end_pend_d;
    logic [7:0]    end_idx_q, end_idx_d;

    mp1000_dl_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Download edges and filtering of strobes into in-range BIOS/cart pushes.
    always_comb begin
        dl_rise    = ioctl_download & ~dl_q;
        dl_fall    = ~ioctl_download & dl_q;
        bios_hit   = (ioctl_index == BIOS_INDEX) && (ioctl_addr < 25'(BIOS_SIZE));
        cart_hit   = (ioctl_index == CART_INDEX) && (ioctl_addr < 25'(CART_SIZE));
        push_req   = ioctl_wr & (bios_hit | cart_hit);
        push_addr  = (bios_hit ? AW'(BIOS_BASE) : AW'(CART_BASE)) + ioctl_addr[AW-1:0];
        fifo_push  = push_req & ~fifo_full;
        fifo_wdata = {push_addr, ioctl_dout};
        cart_off1  = ioctl_addr[15:0] + 16'd1;
    end

    // Arbiter next state: alternate priority when the CPU and the FIFO both want the port.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_din_d    = mem_din_q;
        cpu_ack_d    = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req && (fifo_empty || last_grant_q == GRANT_DL)) begin
                    last_grant_d = GRANT_CPU;
                    mem_addr_d   = cpu_addr;
                    if (cpu_we) begin
                        state_d   = ARB_CPU_WR;
                        mem_we_d  = 1'b1;
                        mem_din_d = cpu_din;
                        cpu_ack_d = 1'b1;
                    end else begin
                        state_d = ARB_CPU_RD;
                    end
                end else if (!fifo_empty) begin
                    last_grant_d = GRANT_DL;
                    fifo_pop     = 1'b1;
                    mem_addr_d   = fifo_rdata[DW-1:8];
                    mem_din_d    = fifo_rdata[7:0];
                    mem_we_d     = 1'b1;
                    state_d      = ARB_DL_WR;
                end
            end
            ARB_CPU_RD: state_d = ARB_CPU_DONE;
            ARB_CPU_DONE: begin
                cpu_dout_d = mem_dout;
                cpu_ack_d  = 1'b1;
                state_d    = ARB_IDLE;
            end
            ARB_CPU_WR: state_d = ARB_IDLE;
            ARB_DL_WR:  state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Arbiter FSM register with its registered memory and CPU outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_DL;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_din_q    <= mem_din_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_dout_q   <= cpu_dout_d;
        end
    end

    // Load status, reset hold sequencing and loader throttling.
    // Later assignments deliberately override earlier ones: a new download beats a completion.
    always_comb begin
        core_reset_d    = core_reset_q;
        hold_d          = hold_q;
        bios_loaded_d   = bios_loaded_q;
        cart_loaded_d   = cart_loaded_q;
        cart_size_d     = cart_size_q;
        overflow_d      = overflow_q;
        idx_d           = idx_q;
        end_pend_d      = end_pend_q;
        end_idx_d       = end_idx_q;
        fifo_count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        ioctl_wait_d    = (fifo_count_next >= CW'(FIFO_DEPTH - 1));

        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end
        if (fifo_push && cart_hit) begin
            cart_size_d = max16(cart_size_q, cart_off1);
        end
        if (hold_q != '0) begin
            hold_d = hold_q - 16'd1;
            if (hold_q == 16'd1) begin
                core_reset_d = 1'b0;
            end
        end
        if (end_pend_q && fifo_empty && (state_q == ARB_IDLE)) begin
            end_pend_d = 1'b0;
            if (end_idx_q == BIOS_INDEX) bios_loaded_d = 1'b1;
            if (end_idx_q == CART_INDEX) cart_loaded_d = 1'b1;
            if (!ioctl_download) begin
                hold_d       = 16'(RESET_HOLD);
                core_reset_d = 1'b1;
            end
        end
        if (dl_fall) begin
            end_pend_d = 1'b1;
            end_idx_d  = idx_q;
        end
        if (dl_rise) begin
            idx_d        = ioctl_index;
            core_reset_d = 1'b1;
            hold_d       = '0;
            if (ioctl_index == BIOS_INDEX) bios_loaded_d = 1'b0;
            if (ioctl_index == CART_INDEX) begin
                cart_loaded_d = 1'b0;
                cart_size_d   = '0;
            end
        end
    end

    // Status and edge-detect registers; core stays in reset out of power-on.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q          <= 1'b0;
            ioctl_wait_q  <= 1'b0;
            core_reset_q  <= 1'b1;
            hold_q        <= '0;
            bios_loaded_q <= 1'b0;
            cart_loaded_q <= 1'b0;
            cart_size_q   <= '0;
            overflow_q    <= 1'b0;
            idx_q         <= '0;
            end_pend_q    <= 1'b0;
            end_idx_q     <= '0;
        end else begin
            dl_q          <= ioctl_download;
            ioctl_wait_q  <= ioctl_wait_d;
            core_reset_q  <= core_reset_d;
            hold_q        <= hold_d;
            bios_loaded_q <= bios_loaded_d;
            cart_loaded_q <= cart_loaded_d;
            cart_size_q   <= cart_size_d;
            overflow_q    <= overflow_d;
            idx_q         <= idx_d;
            end_pend_q    <= end_pend_d;
            end_idx_q     <= end_idx_d;
        end
    end

    assign ioctl_wait  = ioctl_wait_q;
    assign cpu_dout    = cpu_dout_q;
    assign cpu_ack     = cpu_ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_din     = mem_din_q;
    assign core_reset  = core_reset_q;
    assign bios_loaded = bios_loaded_q;
    assign cart_loaded = cart_loaded_q;
    assign cart_size   = cart_size_q;
    assign overflow    = overflow_q;

endmodule
